// File: rtl/keypad_if.sv
// Keypad bus between the raw key/enable source and the debounce encoder.
// master drives the key lines and enable; slave returns the accepted code,
// its valid level and a one-cycle press strobe.
interface keypad_if #(
  parameter int NUM_KEYS = 10,
  parameter int CODE_W   = $clog2(NUM_KEYS)
);
  // No backpressure on this bus. valid is a level that is high while a key is
  // held or releasing; D is stable whenever valid is high. key_strobe pulses
  // once, in the same cycle that valid rises.
  logic                enablen;
  logic [NUM_KEYS-1:0] keypad;
  logic [CODE_W-1:0]   D;
  logic                valid;
  logic                key_strobe;

  modport master (output enablen, keypad, input D, valid, key_strobe);
  modport slave  (input enablen, keypad, output D, valid, key_strobe);
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: 2-flop synchroniser, priority encoder, debounce FSM and
// one press strobe per accepted key. dbg_state exposes the FSM state.
module keypad_debounce_encoder #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = $clog2(NUM_KEYS),
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  keypad_if.slave    kif,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_KEYS-1:0] s1, s2;
  logic [CODE_W-1:0]   cand;
  logic [CODE_W-1:0]   code;
  logic                any;

  // Highest pressed index wins, so later iterations override earlier ones.
  always_comb begin
    any  = |s2;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (s2[i]) code = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1             <= '0;
      s2             <= '0;
      state          <= IDLE;
      cnt            <= '0;
      cand           <= '0;
      kif.D          <= '0;
      kif.valid      <= 1'b0;
      kif.key_strobe <= 1'b0;
    end else begin
      s1             <= kif.keypad;
      s2             <= s1;
      kif.key_strobe <= 1'b0;
      // Disable parks the FSM but keeps D, so the last accepted digit survives.
      if (kif.enablen) begin
        state     <= IDLE;
        cnt       <= '0;
        kif.valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            kif.valid <= 1'b0;
            if (any) begin
              state <= DEBOUNCE;
              cand  <= code;
              cnt   <= '0;
            end
          end
          DEBOUNCE: begin
            if (!any) begin
              state <= IDLE;
            end else if (code != cand) begin
              cand <= code;
              cnt  <= '0;
            end else if (cnt == LAST) begin
              state          <= HELD;
              kif.D          <= cand;
              kif.valid      <= 1'b1;
              kif.key_strobe <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!any) begin
              state <= RELEASE;
              cnt   <= '0;
            end
          end
          RELEASE: begin
            // Keys reappearing here are release bounce: back to HELD, no strobe.
            if (any) begin
              state <= HELD;
            end else if (cnt == LAST) begin
              state     <= IDLE;
              kif.valid <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder (10 keys, 4-cycle debounce):
// a vector table plus hand-written latency, bounce and reset sequences.
module tb_keypad_debounce_encoder;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  keypad_if #(.NUM_KEYS(10)) kif ();

  keypad_debounce_encoder #(.NUM_KEYS(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .kif       (kif),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // monitor: strobe count and strobe protocol checks, sampled on the falling edge
  int   strobe_cnt = 0;
  int   proto_err  = 0;
  logic prev_strobe = 1'b0;
  logic prev_valid  = 1'b0;
  always @(negedge clk) begin
    if (kif.key_strobe === 1'b1) begin
      strobe_cnt++;
      if (prev_strobe !== 1'b0 || prev_valid !== 1'b0) proto_err++;
    end
    prev_strobe = kif.key_strobe;
    prev_valid  = kif.valid;
  end

  typedef struct {
    logic [9:0] keypad;
    logic       enablen;
    int         hold;
    int         exp_strobes;
    int         exp_d;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [9:0] kp, input logic en, input int hold,
                         input int strobes, input int d, input logic vld);
    vec_t v;
    v.keypad      = kp;
    v.enablen     = en;
    v.hold        = hold;
    v.exp_strobes = strobes;
    v.exp_d       = d;
    v.exp_valid   = vld;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int base;
  int valid_drops;

  initial begin
    // after test 2, D=5 and idle
    add_vec(10'h084, 1'b0, 10, 1, 7, 1'b1);   // keys 7+2 -> 7
    add_vec(10'h004, 1'b0, 10, 0, 7, 1'b1);   // drop key 7: ignored
    add_vec(10'h000, 1'b0, 10, 0, 7, 1'b0);   // release
    add_vec(10'h200, 1'b0, 10, 1, 9, 1'b1);   // key 9
    add_vec(10'h201, 1'b0, 5,  0, 9, 1'b1);   // extra key during HELD
    add_vec(10'h000, 1'b0, 3,  0, 9, 1'b1);   // short release, still releasing
    add_vec(10'h200, 1'b0, 8,  0, 9, 1'b1);   // release bounce back to HELD
    add_vec(10'h200, 1'b1, 3,  0, 9, 1'b0);   // disable drops valid, keeps D
    for (int i = 0; i < 10; i++) add_vec(10'(1 << i), 1'b1, 3, 0, 9, 1'b0);
    add_vec(10'h010, 1'b1, 5,  0, 9, 1'b0);   // key 4 held while disabled
    add_vec(10'h010, 1'b0, 10, 1, 4, 1'b1);   // enable with key held: fresh strobe
    add_vec(10'h000, 1'b0, 10, 0, 4, 1'b0);

    // test 1: reset
    reset       = 1'b1;
    kif.enablen = 1'b0;
    kif.keypad  = '0;
    step(2);
    check("reset_D", int'(kif.D), 0);
    check("reset_valid", int'(kif.valid), 0);
    check("reset_strobe", int'(kif.key_strobe), 0);
    check("reset_state", int'(dbg_state), 0);
    reset = 1'b0;
    step(2);

    // test 2: latency of press and release for key 5
    base = strobe_cnt;
    kif.keypad = 10'h020;
    step(6);   // after edge k+5
    check("press_early_strobe", int'(kif.key_strobe), 0);
    check("press_early_valid", int'(kif.valid), 0);
    step(1);   // after edge k+6
    check("press_strobe", int'(kif.key_strobe), 1);
    check("press_valid", int'(kif.valid), 1);
    check("press_D", int'(kif.D), 5);
    step(1);
    check("press_strobe_1cyc", int'(kif.key_strobe), 0);
    step(12);
    check("press_strobe_count", strobe_cnt - base, 1);
    kif.keypad = '0;
    step(6);   // after edge r+5
    check("release_early_valid", int'(kif.valid), 1);
    step(1);   // after edge r+6
    check("release_valid", int'(kif.valid), 0);
    check("release_D", int'(kif.D), 5);
    step(2);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      base        = strobe_cnt;
      kif.keypad  = vecs[i].keypad;
      kif.enablen = vecs[i].enablen;
      step(vecs[i].hold);
      check($sformatf("vec%0d_strobes", i), strobe_cnt - base, vecs[i].exp_strobes);
      check($sformatf("vec%0d_D", i), int'(kif.D), vecs[i].exp_d);
      check($sformatf("vec%0d_valid", i), int'(kif.valid), int'(vecs[i].exp_valid));
    end

    // test 4: press bounce on key 3, then a one-cycle glitch while held
    base = strobe_cnt;
    for (int i = 0; i < 4; i++) begin
      kif.keypad = (i % 2 == 0) ? 10'h008 : 10'h000;
      step(1);
    end
    kif.keypad = 10'h008;
    step(12);
    check("bounce_strobes", strobe_cnt - base, 1);
    check("bounce_D", int'(kif.D), 3);
    check("bounce_valid", int'(kif.valid), 1);
    base        = strobe_cnt;
    valid_drops = 0;
    kif.keypad  = 10'h000;
    step(1);
    if (kif.valid !== 1'b1) valid_drops++;
    kif.keypad = 10'h008;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (kif.valid !== 1'b1) valid_drops++;
    end
    check("glitch_strobes", strobe_cnt - base, 0);
    check("glitch_valid_drops", valid_drops, 0);
    check("glitch_D", int'(kif.D), 3);
    kif.keypad = '0;
    step(10);

    // test 6: reset in the middle of key 9 debounce
    base       = strobe_cnt;
    kif.keypad = 10'h200;
    step(4);
    check("abort_in_debounce", int'(dbg_state), 1);
    reset      = 1'b1;
    kif.keypad = '0;
    step(2);
    reset = 1'b0;
    step(10);
    check("abort_strobes", strobe_cnt - base, 0);
    check("abort_valid", int'(kif.valid), 0);
    check("abort_D", int'(kif.D), 0);

    check("strobe_protocol", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
